// File: rtl/imm_pkg.sv
// ============================================================================
// Module   : imm_pkg
// Brief    : Shared types and helpers for the immediate encoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package imm_pkg;

    typedef enum logic [1:0] {
        IMM8   = 2'b00,
        IMM12  = 2'b01,
        BRANCH = 2'b10,
        ROTIMM = 2'b11
    } imm_src_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SEARCH = 2'b01,
        FIN    = 2'b10
    } enc_state_t;

    localparam int ROT_W = 4;

    // A zero shift makes the right-hand term shift by 32, which yields 0.
    function automatic logic [31:0] rol32(input logic [31:0] x, input logic [4:0] sh);
        rol32 = (x << sh) | (x >> (6'd32 - {1'b0, sh}));
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_rot_check.sv
// ============================================================================
// Module   : imm_rot_check
// Brief    : Tests whether value rotated left by 2*rot fits in 8 bits.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_rot_check
    import imm_pkg::*;
(
    input  logic [31:0]      value,
    input  logic [ROT_W-1:0] rot,
    output logic             hit,
    output logic [7:0]       imm8
);

    logic [31:0] w_rot;

    assign w_rot = rol32(value, {rot, 1'b0});
    assign hit   = (w_rot[31:8] == 24'h0);
    assign imm8  = w_rot[7:0];

endmodule

`default_nettype wire

// File: rtl/imm_encode.sv
// ============================================================================
// Module   : imm_encode
// Brief    : Inverse of the extend unit: builds Instr[23:0] for a target value.
// Revision : 1.0
// ============================================================================
`default_nettype none

module imm_encode
    import imm_pkg::*;
#(
    parameter int NROT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] value,
    input  logic [1:0]  imm_src,
    output logic        busy,
    output logic        done,
    output logic        ok,
    output logic [23:0] instr_field
);

    localparam logic [ROT_W-1:0] c_ROT_MAX = ROT_W'(NROT - 1);

    enc_state_t       r_state;
    enc_state_t       w_next;
    logic [31:0]      r_value;
    imm_src_t         r_src;
    logic [ROT_W-1:0] r_rot;
    logic             r_busy;
    logic             r_done;
    logic             r_ok;
    logic [23:0]      r_field;

    logic             w_accept;
    logic             w_hit;
    logic [7:0]       w_imm8;
    logic             w_last_rot;
    logic             w_load;
    logic             w_res_ok;
    logic [23:0]      w_res_field;

    // busy stays high through the done cycle, so a start there is never taken.
    assign w_accept   = start && !r_busy;
    assign w_last_rot = (r_rot == c_ROT_MAX);

    imm_rot_check u_rot_check (
        .value (r_value),
        .rot   (r_rot),
        .hit   (w_hit),
        .imm8  (w_imm8)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = (imm_src == ROTIMM) ? SEARCH : FIN;
                end
            end
            SEARCH: begin
                if (w_hit || w_last_rot) begin
                    w_next = IDLE;
                end
            end
            FIN:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load      = 1'b0;
        w_res_ok    = 1'b0;
        w_res_field = 24'h0;
        case (r_state)
            FIN: begin
                w_load = 1'b1;
                case (r_src)
                    IMM8: begin
                        w_res_ok    = (r_value[31:8] == 24'h0);
                        w_res_field = w_res_ok ? {16'h0, r_value[7:0]} : 24'h0;
                    end
                    IMM12: begin
                        w_res_ok    = (r_value[31:12] == 20'h0);
                        w_res_field = w_res_ok ? {12'h0, r_value[11:0]} : 24'h0;
                    end
                    BRANCH: begin
                        w_res_ok    = (r_value[1:0] == 2'b00) &&
                                      (r_value[31:25] == {7{r_value[25]}});
                        w_res_field = w_res_ok ? r_value[25:2] : 24'h0;
                    end
                    default: begin
                        w_res_ok    = 1'b0;
                        w_res_field = 24'h0;
                    end
                endcase
            end
            SEARCH: begin
                if (w_hit) begin
                    w_load      = 1'b1;
                    w_res_ok    = 1'b1;
                    w_res_field = {12'h0, r_rot, w_imm8};
                end else if (w_last_rot) begin
                    w_load      = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_value <= 32'h0;
            r_src   <= IMM8;
            r_rot   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ok    <= 1'b0;
            r_field <= 24'h0;
        end else begin
            r_done <= w_load;
            if (w_accept) begin
                r_value <= value;
                r_src   <= imm_src_t'(imm_src);
                r_rot   <= '0;
                r_busy  <= 1'b1;
            end else if (r_done) begin
                r_busy  <= 1'b0;
            end
            if (w_load) begin
                r_ok    <= w_res_ok;
                r_field <= w_res_field;
            end
            // Saturating: the last candidate ends the search, so no wrap.
            if (r_state == SEARCH && !w_hit && !w_last_rot) begin
                r_rot <= r_rot + 1'b1;
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign ok          = r_ok;
    assign instr_field = r_field;

endmodule

`default_nettype wire

// File: tb/tb_imm_encode.sv
// ============================================================================
// Module   : tb_imm_encode
// Brief    : Self-checking bench for imm_encode against a behavioural model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_imm_encode;

    localparam int NROT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] value;
    logic [1:0]  imm_src;
    logic        busy;
    logic        done;
    logic        ok;
    logic [23:0] instr_field;

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    imm_encode #(.NROT(NROT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .value       (value),
        .imm_src     (imm_src),
        .busy        (busy),
        .done        (done),
        .ok          (ok),
        .instr_field (instr_field)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference encoder: what field/ok the spec demands, and how many edges it takes.
    function automatic void ref_encode(input logic [31:0] v, input logic [1:0] md,
                                       output logic rok, output logic [23:0] rf, output int lat);
        logic [31:0] r;
        int          s;
        rok = 1'b0;
        rf  = 24'h0;
        lat = 1;
        s   = int'(v);
        case (md)
            2'd0: if (v < 32'h100)  begin rok = 1'b1; rf = v[23:0]; end
            2'd1: if (v < 32'h1000) begin rok = 1'b1; rf = v[23:0]; end
            2'd2: if ((v % 4) == 0 && s >= -(1 << 25) && s < (1 << 25)) begin
                      rok = 1'b1;
                      rf  = v[25:2];
                  end
            default: begin
                lat = NROT;
                for (int k = 0; k < NROT; k++) begin
                    r = v;
                    repeat (2 * k) r = {r[30:0], r[31]};
                    if (r < 32'h100) begin
                        rok = 1'b1;
                        rf  = {12'h0, 4'(k), r[7:0]};
                        lat = k + 1;
                        break;
                    end
                end
            end
        endcase
    endfunction

    // What the extend unit regenerates from a field.
    function automatic logic [31:0] ext(input logic [23:0] f, input logic [1:0] md);
        logic [31:0] r;
        case (md)
            2'd0:    r = {24'h0, f[7:0]};
            2'd1:    r = {20'h0, f[11:0]};
            2'd2:    r = {{6{f[23]}}, f, 2'b00};
            default: begin
                r = {24'h0, f[7:0]};
                repeat (2 * int'(f[11:8])) r = {r[0], r[31:1]};
            end
        endcase
        return r;
    endfunction

    logic        c_ok;
    logic [23:0] c_f;
    int          c_lat;
    always_comb ref_encode(value, imm_src, c_ok, c_f, c_lat);

    logic        m_busy, m_done, m_ok, p_ok;
    logic [23:0] m_field, p_field;
    logic [31:0] m_val;
    logic [1:0]  m_mode;
    int          m_cnt;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_ok <= 1'b0; m_field <= 24'h0; m_cnt <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_done) m_busy <= 1'b0;
            if (!m_busy && start) begin
                m_busy <= 1'b1; m_cnt <= c_lat; p_ok <= c_ok; p_field <= c_f;
                m_val <= value; m_mode <= imm_src;
            end else if (m_busy && m_cnt != 0) begin
                if (m_cnt == 1) begin
                    m_done <= 1'b1; m_ok <= p_ok; m_field <= p_field;
                end
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'h0, busy}, {31'h0, m_busy});
            check("done", {31'h0, done}, {31'h0, m_done});
            check("ok",   {31'h0, ok},   {31'h0, m_ok});
            check("field", {8'h0, instr_field}, {8'h0, m_field});
            if (done && ok) check("roundtrip", ext(instr_field, m_mode), m_val);
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issues one request; lit=1 pins the result to hand-computed values.
    task automatic do_req(input string nm, input logic [31:0] v, input logic [1:0] md,
                          input bit lit, input logic eok, input logic [23:0] ef, input int elat,
                          input bit inject, input bit stray);
        int n   = 0;
        bit got = 0;
        wait_idle();
        value = v; imm_src = md; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (n < 40 && !got) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) begin
                got   = 1;
                start = 1'b0;
            end else if (inject && n == 2) begin
                start = 1'b1; value = 32'h000000AB; imm_src = 2'b00;
            end else if (stray) begin
                start = ($urandom % 5) == 0; value = $urandom; imm_src = 2'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        if (!got) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
        end else if (lit) begin
            check({nm, "_lat"},   32'(n), 32'(elat));
            check({nm, "_ok"},    {31'h0, ok}, {31'h0, eok});
            check({nm, "_field"}, {8'h0, instr_field}, {8'h0, ef});
        end
    endtask

    initial begin
        logic [1:0]  md;
        logic [31:0] v;
        reset = 1'b1; start = 1'b0; value = 32'h0; imm_src = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", {31'h0, busy}, 32'd0);
        check("rst_done", {31'h0, done}, 32'd0);
        check("rst_ok",   {31'h0, ok},   32'd0);
        check("rst_field", {8'h0, instr_field}, 32'd0);
        reset = 1'b0;

        do_req("m0_3f",   32'h0000003F, 2'b00, 1, 1'b1, 24'h00003F, 1,  0, 0);
        do_req("m0_100",  32'h00000100, 2'b00, 1, 1'b0, 24'h000000, 1,  0, 0);
        do_req("m1_abc",  32'h00000ABC, 2'b01, 1, 1'b1, 24'h000ABC, 1,  0, 0);
        do_req("m1_1000", 32'h00001000, 2'b01, 1, 1'b0, 24'h000000, 1,  0, 0);
        do_req("m2_neg",  32'hFE000000, 2'b10, 1, 1'b1, 24'h800000, 1,  0, 0);
        do_req("m2_mis",  32'h00000006, 2'b10, 1, 1'b0, 24'h000000, 1,  0, 0);
        do_req("m2_big",  32'h02000000, 2'b10, 1, 1'b0, 24'h000000, 1,  0, 0);
        do_req("m3_ff",   32'hFF000000, 2'b11, 1, 1'b1, 24'h0004FF, 5,  0, 0);
        do_req("m3_miss", 32'h00000101, 2'b11, 1, 1'b0, 24'h000000, 16, 0, 0);
        do_req("m3_zero", 32'h00000000, 2'b11, 1, 1'b1, 24'h000000, 1,  0, 0);
        do_req("m3_last", 32'h000003FC, 2'b11, 1, 1'b1, 24'h000FFF, 16, 0, 0);
        do_req("ignore",  32'hFF000000, 2'b11, 1, 1'b1, 24'h0004FF, 5,  1, 0);

        // Abort a non-hitting search once rot has reached 7.
        wait_idle();
        value = 32'h00000101; imm_src = 2'b11; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", {31'h0, busy}, 32'd0);
        check("abort_done", {31'h0, done}, 32'd0);
        check("abort_ok",   {31'h0, ok},   32'd0);
        check("abort_field", {8'h0, instr_field}, 32'd0);
        reset = 1'b0;
        do_req("after_rst", 32'h0000003F, 2'b00, 1, 1'b1, 24'h00003F, 1, 0, 0);

        for (int i = 0; i < 200; i++) begin
            md = 2'($urandom);
            case ($urandom % 3)
                0:       v = $urandom;
                1:       v = ext(24'($urandom), md);
                default: v = $urandom >> ($urandom % 32);
            endcase
            do_req("rand", v, md, 0, 1'b0, 24'h0, 0, 0, (i % 3) == 0);
            repeat ($urandom % 3) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
